// File: rtl/add_seq_if.sv
// add_seq_if: start/done handshake and operand/result bus for add_seq; ADD_SEQ_OVERFLOW_EN adds overflow.
interface add_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] R1;
  logic [WIDTH-1:0] R2;
  logic carryIn;
  logic busy;
  logic done;
  logic [WIDTH-1:0] R3;
  logic carryOut;
`ifdef ADD_SEQ_OVERFLOW_EN
  logic overflow;
  modport master (output start, R1, R2, carryIn, input busy, done, R3, carryOut, overflow);
  modport slave (input start, R1, R2, carryIn, output busy, done, R3, carryOut, overflow);
`else
  modport master (output start, R1, R2, carryIn, input busy, done, R3, carryOut);
  modport slave (input start, R1, R2, carryIn, output busy, done, R3, carryOut);
`endif
endinterface

// File: rtl/add_seq.sv
// add_seq: multi-cycle adder, CHUNK bits per clock with registered ripple carry; ADD_SEQ_OVERFLOW_EN adds signed overflow.
module add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst,
  add_seq_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("add_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, r3_q, r3_d;
  logic c_q, c_d, co_q, co_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CHUNK-1:0] a_s, b_s, s_s;
  logic c_s, last;
`ifdef ADD_SEQ_OVERFLOW_EN
  logic ov_q, ov_d;
  assign bus.overflow = ov_q;
`endif
  always_comb begin
    a_s = a_q[idx_q*CHUNK +: CHUNK];
    b_s = b_q[idx_q*CHUNK +: CHUNK];
    {c_s, s_s} = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, c_q};
    last = idx_q == IW'(N - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    idx_d = idx_q;
    sum_d = sum_q;
    r3_d = r3_q;
    co_d = co_q;
`ifdef ADD_SEQ_OVERFLOW_EN
    ov_d = ov_q;
`endif
    if (state_q == RUN) begin
      sum_d[idx_q*CHUNK +: CHUNK] = s_s;
      c_d = c_s;
      idx_d = idx_q + 1'b1;
      state_d = last ? DONE : RUN;
      r3_d = last ? sum_d : r3_q;
      co_d = last ? c_s : co_q;
`ifdef ADD_SEQ_OVERFLOW_EN
      // carry into the MSB is recovered from the MSB's own sum bit
      ov_d = last ? (a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ s_s[CHUNK-1] ^ c_s) : ov_q;
`endif
    end else if (bus.start) begin
      a_d = bus.R1;
      b_d = bus.R2;
      c_d = bus.carryIn;
      idx_d = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      idx_q <= '0;
      sum_q <= '0;
      r3_q <= '0;
      co_q <= 1'b0;
`ifdef ADD_SEQ_OVERFLOW_EN
      ov_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      r3_q <= r3_d;
      co_q <= co_d;
`ifdef ADD_SEQ_OVERFLOW_EN
      ov_q <= ov_d;
`endif
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.R3 = r3_q;
  assign bus.carryOut = co_q;
endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: directed checks of add_seq timing, arithmetic, start-ignore, abort and back-to-back starts.
module tb_add_seq;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  add_seq_if #(.WIDTH(WIDTH)) bus ();
  add_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    bus.start = 1'b1;
    bus.R1 = a;
    bus.R2 = b;
    bus.carryIn = ci;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.R1 = '0;
    bus.R2 = '0;
    bus.carryIn = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.carryOut} !== 3'b000 || bus.R3 !== 32'h0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b R3=%h carryOut=%b, required all 0", bus.busy, bus.done, bus.R3, bus.carryOut);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_timing();
    pulse_start(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        failures++;
        $display("FAIL timing_busy_k+%0d: busy=%b done=%b, required 1 0", i, bus.busy, bus.done);
      end
      tick();
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b01 || bus.R3 !== 32'h0 || bus.carryOut !== 1'b1) begin
      failures++;
      $display("FAIL timing_done: busy=%b done=%b R3=%h co=%b, required 0 1 00000000 1", bus.busy, bus.done, bus.R3, bus.carryOut);
    end
    tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.R3 !== 32'h0 || bus.carryOut !== 1'b1) begin
      failures++;
      $display("FAIL timing_after_done: busy=%b done=%b R3=%h co=%b, required 0 0 00000000 1", bus.busy, bus.done, bus.R3, bus.carryOut);
    end
  endtask

  task automatic test_values();
    logic [WIDTH-1:0] va [4] = '{32'h1234_5678, 32'h0000_00FF, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [WIDTH-1:0] vb [4] = '{32'h1111_1111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    logic vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] er [4] = '{32'h2345_678A, 32'h0000_0100, 32'h0000_0001, 32'hDEAD_BEF0};
    logic ec [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      pulse_start(va[v], vb[v], vc[v]);
      repeat (4) tick();
      checks++;
      if (bus.done !== 1'b1 || bus.R3 !== er[v] || bus.carryOut !== ec[v]) begin
        failures++;
        $display("FAIL values_%0d: done=%b R3=%h co=%b, required 1 %h %b", v, bus.done, bus.R3, bus.carryOut, er[v], ec[v]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int extra_done = 0;
    pulse_start(32'h1234_5678, 32'h1111_1111, 1'b1);
    tick();
    bus.start = 1'b1;
    bus.R1 = 32'hFFFF_FFFF;
    bus.R2 = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.R3 !== 32'h2345_678A || bus.carryOut !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_result: done=%b R3=%h co=%b, required 1 2345678a 0", bus.done, bus.R3, bus.carryOut);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || bus.R3 !== 32'h2345_678A) begin
      failures++;
      $display("FAIL ignore_start_no_rerun: active_cycles=%0d R3=%h, required 0 2345678a", extra_done, bus.R3);
    end
  endtask

  task automatic test_abort();
    int stray = 0;
    pulse_start(32'h0000_00FF, 32'h0000_0001, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.carryOut} !== 3'b000 || bus.R3 !== 32'h0) begin
      failures++;
      $display("FAIL abort_clear: busy=%b done=%b R3=%h co=%b, required all 0", bus.busy, bus.done, bus.R3, bus.carryOut);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL abort_no_done: active_cycles=%0d, required 0", stray);
    end
    pulse_start(32'h0000_00FF, 32'h0000_0001, 1'b0);
    repeat (4) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.R3 !== 32'h0000_0100 || bus.carryOut !== 1'b0) begin
      failures++;
      $display("FAIL abort_restart: done=%b R3=%h co=%b, required 1 00000100 0", bus.done, bus.R3, bus.carryOut);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    pulse_start(32'h0000_0010, 32'h0000_0020, 1'b0);
    repeat (4) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.R3 !== 32'h0000_0030) begin
      failures++;
      $display("FAIL b2b_first: done=%b R3=%h, required 1 00000030", bus.done, bus.R3);
    end
    pulse_start(32'h0000_0005, 32'h0000_0007, 1'b0);
    checks++;
    if ({bus.busy, bus.done} !== 2'b10 || bus.R3 !== 32'h0000_0030) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b done=%b R3=%h, required 1 0 00000030", bus.busy, bus.done, bus.R3);
    end
    repeat (4) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.R3 !== 32'h0000_000C || bus.carryOut !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: done=%b R3=%h co=%b, required 1 0000000c 0", bus.done, bus.R3, bus.carryOut);
    end
    tick();
  endtask

`ifdef ADD_SEQ_OVERFLOW_EN
  task automatic test_overflow();
    pulse_start(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (4) tick();
    checks++;
    if (bus.R3 !== 32'h8000_0000 || bus.overflow !== 1'b1 || bus.carryOut !== 1'b0) begin
      failures++;
      $display("FAIL overflow_pos: R3=%h ov=%b co=%b, required 80000000 1 0", bus.R3, bus.overflow, bus.carryOut);
    end
    tick();
    pulse_start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_hold: ov=%b, required 1", bus.overflow);
    end
    repeat (4) tick();
    checks++;
    if (bus.R3 !== 32'h0 || bus.overflow !== 1'b0 || bus.carryOut !== 1'b1) begin
      failures++;
      $display("FAIL overflow_none: R3=%h ov=%b co=%b, required 00000000 0 1", bus.R3, bus.overflow, bus.carryOut);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_values();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef ADD_SEQ_OVERFLOW_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Multi-cycle adder; the additive counterpart of the team's combinational subtractor.
- Computes R3 = R1 + R2 + carryIn one CHUNK-bit slice per clock, rippling carry between slices through a register.
- Sits in the ALU next to the subtractor. Used where a full-width single-cycle carry chain would not meet timing.
- Start/done handshake toward the ALU control FSM.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH must be a multiple of CHUNK, otherwise elaboration fails.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- R1  input  WIDTH  addend A; captured on accepted start.
- R2  input  WIDTH  addend B; captured on accepted start.
- carryIn  input  1  carry into bit 0; captured on accepted start.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse; result valid.
- R3  output  WIDTH  sum, registered.
- carryOut  output  1  carry out of bit WIDTH-1, registered.

Behaviour:
- Reset (async, active-high): state=IDLE; busy, done, R3, carryOut = 0. Internal operand, carry and slice-index registers also clear.
- N = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches R1, R2 and carryIn, clears slice index, and moves to RUN. start=0 stays in IDLE.
- RUN: each cycle adds slice i of both operands plus the carry register. It writes the CHUNK-bit result into partial sum slice i, stores the slice carry into the carry register, and increments i.
- RUN exit: after the slice N-1 edge, go to DONE. On that same edge, copy the partial sum to R3 and the final carry to carryOut.
- DONE: lasts one cycle; done=1. start=1 in DONE is accepted exactly as in IDLE (back-to-back; next state RUN). Otherwise next state IDLE.
- Timing: start high in cycle k means busy=1 in cycles k+1..k+N, done=1 in cycle k+N+1, and R3/carryOut valid from cycle k+N+1.
- busy=1 exactly in RUN; done=1 exactly in DONE.
- R3/carryOut hold their value until the next completion, including throughout the next RUN.
- start while busy is ignored: no restart, no queueing.
- Operand changes after the start edge have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; carryOut is bit WIDTH of the true sum.
- rst asserted mid-RUN aborts the operation immediately: no done, outputs cleared.
- CHUNK=WIDTH is legal: N=1, done in cycle k+2.

Optional Feature:
- Macro: ADD_SEQ_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit) giving signed two's-complement overflow of the sum. It equals the carry into bit WIDTH-1 XOR carryOut, is registered alongside R3, resets to 0, and holds like R3.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, CHUNK=8; reset, then start with R1=0x0000_0001, R2=0xFFFF_FFFF, carryIn=0 -> busy high for 4 cycles, done in cycle k+5, R3=0x0000_0000, carryOut=1.
- R1=0x1234_5678, R2=0x1111_1111, carryIn=1 -> R3=0x2345_678A, carryOut=0. Separately, R1=0x0000_00FF, R2=0x0000_0001, carryIn=0 -> R3=0x0000_0100, carry crosses the slice boundary.
- During busy, pulse start with R1=R2=0xFFFF_FFFF -> ignored; the first result completes on schedule and no second done follows.
- Assert rst in cycle k+2 of a run -> busy, done, R3 and carryOut read 0 immediately; no done pulse afterwards; a new start works normally.
- Assert start in the DONE cycle with R1=5, R2=7, carryIn=0 -> the previous result is visible in that cycle, the new run begins, and R3=0x0000_000C appears 5 cycles later.
- ADD_SEQ_OVERFLOW_EN defined: R1=0x7FFF_FFFF, R2=1 -> R3=0x8000_0000, overflow=1, carryOut=0. R1=0xFFFF_FFFF, R2=1 -> overflow=0, carryOut=1.
